// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and register index type.
package cpu_pkg;
  localparam int NREG = 32;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: increments on issue, decrements on writeback.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             dec_eff;

  // A writeback against an empty counter is an error handled upstream; it must not decrement.
  assign dec_eff = dec && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (inc && !dec_eff && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;
    end else if (dec_eff && !inc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count   = count_reg;
  assign nonzero = (count_reg != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counts, decode stall generation
// and sticky writeback-underflow detection. Register 0 is never tracked.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  input  logic        writereg,
  input  logic [4:0]  rtd,
  output logic        stall,
  output logic        issue_fire,
  output logic [31:0] pending_mask,
  output logic        busy,
  output logic        err_underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             hz_rs;
  logic             hz_rt;
  logic             dest_ovf;
  logic             err_reg;

  // A count of exactly 1 is satisfied by a same-cycle writeback when bypass is enabled,
  // since the register file writes on the falling edge ahead of the decode read.
  function automatic logic src_hazard(input logic use_s, input reg_idx_t s,
                                      input logic [CNT_W-1:0] c);
    logic wb_hit;
    wb_hit = WB_BYPASS && writereg && (rtd == s);
    return use_s && (s != REG_ZERO) &&
           ((c > CNT_ONE) || ((c == CNT_ONE) && !wb_hit));
  endfunction

  always_comb begin
    hz_rs    = src_hazard(issue_use_rs, issue_rs, cnt[issue_rs]);
    hz_rt    = src_hazard(issue_use_rt, issue_rt, cnt[issue_rt]);
    dest_ovf = issue_wr && (issue_rd != REG_ZERO) && (cnt[issue_rd] == CNT_MAX) &&
               !(writereg && (rtd == issue_rd));
  end

  assign stall      = issue_valid && (hz_rs || hz_rt || dest_ovf);
  assign issue_fire = issue_valid && !stall;

  assign cnt[0]          = '0;
  assign inc_vec[0]      = 1'b0;
  assign dec_vec[0]      = 1'b0;
  assign pending_mask[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      assign inc_vec[gi] = issue_fire && issue_wr && (issue_rd == reg_idx_t'(gi));
      assign dec_vec[gi] = writereg && (rtd == reg_idx_t'(gi));

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (inc_vec[gi]),
        .dec     (dec_vec[gi]),
        .count   (cnt[gi]),
        .nonzero (pending_mask[gi])
      );
    end
  endgenerate

  assign busy = |pending_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (writereg && (rtd != REG_ZERO) && (cnt[rtd] == '0)) begin
      err_reg <= 1'b1;
    end
  end

  assign err_underflow = err_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed vectors push expectations, a monitor compares.
module tb_reg_scoreboard;
  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_use_rs;
  logic        issue_use_rt;
  logic        issue_wr;
  logic [4:0]  issue_rd;
  logic        writereg;
  logic [4:0]  rtd;
  logic        stall;
  logic        issue_fire;
  logic [31:0] pending_mask;
  logic        busy;
  logic        err_underflow;

  typedef struct {
    string       name;
    logic        stall;
    logic        fire;
    logic [31:0] mask;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_txn = 0;

  reg_scoreboard #(
    .CNT_W     (2),
    .WB_BYPASS (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_use_rs  (issue_use_rs),
    .issue_use_rt  (issue_use_rt),
    .issue_wr      (issue_wr),
    .issue_rd      (issue_rd),
    .writereg      (writereg),
    .rtd           (rtd),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .pending_mask  (pending_mask),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d %s: stall=%b fire=%b mask=%h busy=%b err=%b", n_txn, e.name,
               stall, issue_fire, pending_mask, busy, err_underflow);
      chk(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
      chk(e.name, "fire", {31'd0, issue_fire}, {31'd0, e.fire});
      chk(e.name, "mask", pending_mask, e.mask);
      chk(e.name, "busy", {31'd0, busy}, {31'd0, e.busy});
      chk(e.name, "err", {31'd0, err_underflow}, {31'd0, e.err});
    end
  end

  task automatic step(input string nm, input logic rst, input logic v,
                      input logic urs, input int rs, input logic urt, input int rt,
                      input logic wr, input int rd, input logic wb, input int wd,
                      input logic es, input logic ef, input logic [31:0] em,
                      input logic eb, input logic ee);
    exp_t e;
    reset        = rst;
    issue_valid  = v;
    issue_use_rs = urs;
    issue_rs     = 5'(rs);
    issue_use_rt = urt;
    issue_rt     = 5'(rt);
    issue_wr     = wr;
    issue_rd     = 5'(rd);
    writereg     = wb;
    rtd          = 5'(wd);
    e.name = nm; e.stall = es; e.fire = ef; e.mask = em; e.busy = eb; e.err = ee;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_rs = '0; issue_rt = '0;
    issue_use_rs = 1'b0; issue_use_rt = 1'b0; issue_wr = 1'b0; issue_rd = '0;
    writereg = 1'b0; rtd = '0;
    @(posedge clk);
    #1;
    //    name          rst v  urs rs urt rt wr rd wb wd  stall fire mask          busy err
    step("reset_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 0);
    step("wr_r5",       0, 1, 0, 0, 0, 0, 1, 5, 0, 0,  0, 1, 32'h0,       0, 0);
    step("rd_r5_haz",   0, 1, 1, 5, 0, 0, 0, 0, 0, 0,  1, 0, 32'h20,      1, 0);
    step("rd_r5_byp",   0, 1, 1, 5, 0, 0, 0, 0, 1, 5,  0, 1, 32'h20,      1, 0);
    step("r5_clear",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 0);
    step("wr_r8_a",     0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  0, 1, 32'h0,       0, 0);
    step("wr_r8_b",     0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  0, 1, 32'h100,     1, 0);
    step("wr_r8_c",     0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  0, 1, 32'h100,     1, 0);
    step("wr_r8_ovf",   0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  1, 0, 32'h100,     1, 0);
    step("wr_r8_wb",    0, 1, 0, 0, 0, 0, 1, 8, 1, 8,  0, 1, 32'h100,     1, 0);
    step("wr_r8_still", 0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  1, 0, 32'h100,     1, 0);
    step("r8_drain3",   0, 1, 1, 8, 0, 0, 0, 0, 1, 8,  1, 0, 32'h100,     1, 0);
    step("r8_drain2",   0, 1, 1, 8, 0, 0, 0, 0, 1, 8,  1, 0, 32'h100,     1, 0);
    step("r8_drain1",   0, 1, 1, 8, 0, 0, 0, 0, 1, 8,  0, 1, 32'h100,     1, 0);
    step("r8_empty",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 0);
    step("wr_r0",       0, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h0,       0, 0);
    step("rd_r0",       0, 1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 1, 32'h0,       0, 0);
    step("wb_r0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 32'h0,       0, 0);
    step("wb_r0_noerr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 0);
    step("wb_r9_undf",  0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 32'h0,       0, 0);
    step("err_set",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 1);
    step("err_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 1);
    step("err_reset",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 1);
    step("err_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 0);
    step("wr_r3_a",     0, 1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 32'h0,       0, 0);
    step("wr_r3_b",     0, 1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 32'h8,       1, 0);
    step("rst_w_issue", 1, 1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 32'h8,       1, 0);
    step("rd_r3_post",  0, 1, 1, 3, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0,       0, 0);
    step("rs_eq_rd_r7", 0, 1, 1, 7, 0, 0, 1, 7, 0, 0,  0, 1, 32'h0,       0, 0);
    step("rt_r7_haz",   0, 1, 0, 0, 1, 7, 0, 0, 0, 0,  1, 0, 32'h80,      1, 0);
    step("rt_r7_byp",   0, 1, 0, 0, 1, 7, 0, 0, 1, 7,  0, 1, 32'h80,      1, 0);
    step("wr_r2",       0, 1, 0, 0, 0, 0, 1, 2, 0, 0,  0, 1, 32'h0,       0, 0);
    step("rs2_unused",  0, 1, 0, 2, 0, 0, 0, 0, 0, 0,  0, 1, 32'h4,       1, 0);
    step("novalid_haz", 0, 0, 1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 32'h4,       1, 0);
    step("wb_r2",       0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 0, 32'h4,       1, 0);
    step("final_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,       0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks in-flight writes to the 32 × 32-bit MIPS general register file. It sits beside the register file on the decode/issue side of the pipeline and holds a per-register pending-write count. Decode uses it to stall any instruction whose source operand still awaits writeback. Issue increments a destination's count; the writeback port (`writereg`/`rtd`) decrements it.

## Interface
Parameters:
- `CNT_W`, 2: width of each pending counter. Maximum in-flight writes per register is 2^CNT_W − 1.
- `WB_BYPASS`, 1: when 1, a same-cycle writeback satisfies a source whose count is exactly 1. The register file writes on the falling edge, so decode reads the new value.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `issue_rs`, `issue_rt`  in  5 each  source register numbers.
- `issue_use_rs`, `issue_use_rt`  in  1 each  source is actually read.
- `issue_wr`  in  1  instruction writes a register.
- `issue_rd`  in  5  destination register number.
- `writereg`  in  1  writeback commits this cycle.
- `rtd`  in  5  writeback destination.
- `stall`  out  1  combinational; instruction must not issue.
- `issue_fire`  out  1  `issue_valid && !stall`.
- `pending_mask`  out  32  bit i is set when count[i] ≠ 0.
- `busy`  out  1  OR of `pending_mask`.
- `err_underflow`  out  1  sticky; set when a writeback targets a register whose count is 0.

## Operation
Register 0:
- Never tracked. count[0] is constant 0.
- Issue with `issue_rd`=0 does nothing; writeback with `rtd`=0 does nothing.
- Writeback to register 0 never sets `err_underflow`.

Source hazard (per used source s ≠ 0):
- Hazard when count[s] ≥ 2.
- Hazard when count[s] = 1 and not (`WB_BYPASS` && `writereg` && `rtd`==s).

Stall:
- `stall` = `issue_valid` && (any source hazard, or dest overflow).
- Dest overflow = `issue_wr` && `issue_rd`≠0 && count[rd] is at max && not (`writereg` && `rtd`==rd).
- `stall` is 0 whenever `issue_valid` is 0.

Counter update for each register r≠0 at the rising edge:
- inc = `issue_fire` && `issue_wr` && `issue_rd`==r.
- dec = `writereg` && `rtd`==r && count[r]≠0.
- inc && dec: count unchanged.
- inc only: +1.
- dec only: −1.
- Counters never wrap; the overflow stall guarantees this.

Errors:
- `writereg` with `rtd`≠0 and count[rtd]=0 sets `err_underflow` and leaves the counter at 0.
- `err_underflow` clears only on `reset`.

## Timing
- Reset values: all counts 0, `pending_mask`=0, `busy`=0, `err_underflow`=0.
- With no `issue_valid` during reset, `stall`=0 and `issue_fire`=0.
- `reset` takes priority over issue and writeback in the same cycle. Mid-operation it discards all pending state; the pipeline is flushed concurrently.
- `stall` and `issue_fire` have zero latency: combinational from counts and current inputs.
- `pending_mask` and `busy` are registered. They reflect counts after the last edge, so there is 1-cycle latency from issue or writeback.
- Issue handshake: decode holds its inputs stable while `stall`=1. The increment happens only on the edge where `issue_fire`=1.
- Simultaneous issue of rd=r and writeback of r is a net zero change.
- An instruction with rs = rd = r and count[r]=0 does not stall, because the source is read before its own write. It increments count[r].

## Structure
- Shared package `cpu_pkg`:
  - `NREG`=32, `REG_W`=5, `REG_ZERO`=5'd0.
  - typedef `reg_idx_t` (5 bits).
- Sub-module `sb_counter`: one saturating up/down counter with inputs inc and dec, outputs count and nonzero.
- `sb_counter` is instantiated 31 times via a generate loop over registers 1..31.
- The top level holds the hazard comparators, the stall logic and `err_underflow`.

## Test plan
- Reset, then idle: `stall`=0, `pending_mask`=0, `busy`=0, `err_underflow`=0.
- Issue write r5.
  - Next cycle: issue reading rs=5 → `stall`=1, `pending_mask`=32'h20.
  - Then `writereg`=1, `rtd`=5 in the same cycle → with `WB_BYPASS`=1, `stall`=0 and `issue_fire`=1. After the edge, count[5]=0.
- Issue write r8 three times (`CNT_W`=2):
  - count[8]=3.
  - A fourth write to r8 → `stall`=1.
  - The same fourth issue with a concurrent `writereg`/`rtd`=8 → fires; count stays 3.
- Issue write r0, then read rs=0 → never stalls, `pending_mask`=0. `writereg` with `rtd`=0 → no error.
- `writereg` with `rtd`=9 while count[9]=0 → `err_underflow`=1 and it stays 1. Following `reset` → 0.
- count[3]=2, then assert `reset` together with `issue_valid` → next cycle `pending_mask`=0 and issue reading r3 → `stall`=0.
